mips_control_fsm: RTL
=====================

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-003 SHALL have port instr, in, 32, instruction register contents: opcode [31:26], funct [5:0], rt [20:16].
REQ-004 SHALL have port mem_waitrequest, in, 1, memory stall; a transfer completes in a cycle where it is low.
REQ-005 SHALL have port cmp_true, in, 1, ALU result bit 0 during a branch compare.
REQ-006 SHALL have port pc_next_zero, in, 1, high when the jump target is 0x00000000.
REQ-007 SHALL have port alu_control, out, 5, ALU operation code.
REQ-008 SHALL have port src_a_sel, out, 2, ALU A select: 0 PC, 1 rs, 2 shamt, 3 instr index.
REQ-009 SHALL have port src_b_sel, out, 2, ALU B select: 0 rt, 1 sign-ext imm, 2 zero-ext imm, 3 constant 4.
REQ-010 SHALL have ports ir_write, pc_write, reg_write, mem_read, mem_write, out, 1 each, single-cycle strobes.
REQ-011 SHALL have ports active, out, 1, CPU running; and illegal, out, 1, sticky bad-opcode flag.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 FETCH SHALL drive mem_read=1, alu_control=ADD(00010), src_a_sel=0, src_b_sel=3; hold while mem_waitrequest=1.
REQ-014 FETCH SHALL, in the cycle mem_waitrequest=0, pulse ir_write and pc_write, then go to DECODE.
REQ-015 DECODE SHALL last exactly one cycle, with all strobes 0, then go to EXEC.
REQ-016 EXEC SHALL drive alu_control from the decoder: AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SLT 00111, SRA 01000, SLTU 01001, EQ 01010, PASSB 01011, LTZ 01100, LINK 01101, PASSA 01110, LEZ 10000, JCONST 10001.
REQ-017 ALU-type ops (ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA and their I-forms) SHALL go EXEC->WB; WB pulses reg_write, then goes to FETCH.
REQ-018 LW/SW SHALL use ADD with src_b_sel=1 in EXEC, then go to MEM; MEM holds mem_read or mem_write until mem_waitrequest=0; LW then goes to WB, SW to FETCH.
REQ-019 Branches SHALL compute taken = cmp_true XOR invert (BNE, BGEZ, BGTZ invert EQ, LTZ, LEZ); taken pulses pc_write in EXEC; next state FETCH.
REQ-020 J/JAL SHALL use JCONST, JR/JALR PASSA, with pc_write=1 in EXEC; JAL/JALR then go to WB with alu_control=LINK.
REQ-021 Any jump whose EXEC cycle has pc_next_zero=1 SHALL finish its WB (if any), then enter HALT.
REQ-022 HALT SHALL be absorbing until reset, with active=0 and all strobes 0.
REQ-023 Strobes SHALL be Moore-decoded from state plus latched instr; no strobe depends combinationally on cmp_true except the branch pc_write.

Reset
REQ-024 reset high SHALL force all strobes 0, alu_control=00000, src selects 0, active=1, illegal=0 in the same clock edge.
REQ-025 reset asserted in any state, including mid-stall in MEM, SHALL abandon the transfer; the state after reset is FETCH.

Configuration
REQ-026 With ILLEGAL_OPCODE_TRAP_EN defined, an unknown opcode/funct in EXEC SHALL set illegal=1 and enter HALT.
REQ-027 Without ILLEGAL_OPCODE_TRAP_EN, an unknown opcode SHALL execute as a NOP (EXEC->FETCH, no strobes), and illegal SHALL be tied to 0.

Structure
REQ-028 A shared package SHALL hold the alu_op_t enum (codes of REQ-016), state_t, the opcode/funct constants and the src select encodings.
REQ-029 Opcode-to-ALU-op decoding SHALL be one combinational sub-module, mips_alu_decoder (outputs alu_op, src selects, class, invert).

Verification
REQ-030 reset, then ADDIU with mem_waitrequest=0 -> states FETCH, DECODE, EXEC, WB; reg_write high only in cycle 4; alu_control=00010, src_b_sel=1 in EXEC.
REQ-031 LW, with mem_waitrequest=1 for 3 MEM cycles -> mem_read held for 4 cycles, then WB pulses reg_write once.
REQ-032 BNE with cmp_true=1 -> alu_control=01010 and pc_write=0 in EXEC; with cmp_true=0 -> pc_write=1.
REQ-033 JR with pc_next_zero=1 -> pc_write in EXEC, then HALT and active=0; later instr changes produce no strobes.
REQ-034 opcode 6'b111111 -> with the macro: illegal=1 and HALT; without it: return to FETCH with illegal=0.
REQ-035 reset pulsed during a MEM stall -> mem_write=0 on the next edge, FETCH follows, active=1.

Source files
------------

// File: rtl/mips_control_fsm_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
// Optional feature macro: ILLEGAL_OPCODE_TRAP_EN (trap unknown opcodes into HALT).
package mips_control_fsm_pkg;

`ifdef ILLEGAL_OPCODE_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [4:0] {
    ALU_AND    = 5'b00000,
    ALU_OR     = 5'b00001,
    ALU_ADD    = 5'b00010,
    ALU_XOR    = 5'b00011,
    ALU_SLL    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_SUB    = 5'b00110,
    ALU_SLT    = 5'b00111,
    ALU_SRA    = 5'b01000,
    ALU_SLTU   = 5'b01001,
    ALU_EQ     = 5'b01010,
    ALU_PASSB  = 5'b01011,
    ALU_LTZ    = 5'b01100,
    ALU_LINK   = 5'b01101,
    ALU_PASSA  = 5'b01110,
    ALU_LEZ    = 5'b10000,
    ALU_JCONST = 5'b10001
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_JLINK   = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;
  localparam logic [1:0] SRC_A_INDEX = 2'd3;
  localparam logic [1:0] SRC_B_RT    = 2'd0;
  localparam logic [1:0] SRC_B_SIMM  = 2'd1;
  localparam logic [1:0] SRC_B_ZIMM  = 2'd2;
  localparam logic [1:0] SRC_B_FOUR  = 2'd3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational opcode/funct/rt decoder: ALU operation, operand selects,
// instruction class and branch-condition inversion.
module mips_alu_decoder
  import mips_control_fsm_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [4:0]   rt,
  output alu_op_t      alu_op,
  output logic [1:0]   src_a_sel,
  output logic [1:0]   src_b_sel,
  output instr_class_t cls,
  output logic         invert
);

  // Map the instruction fields onto ALU op, operand sources and class
  always_comb begin
    alu_op    = ALU_AND;
    src_a_sel = SRC_A_RS;
    src_b_sel = SRC_B_RT;
    cls       = CLS_ILLEGAL;
    invert    = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        cls = CLS_ALU;
        case (funct)
          FN_SLL:  begin alu_op = ALU_SLL; src_a_sel = SRC_A_SHAMT; end
          FN_SRL:  begin alu_op = ALU_SRL; src_a_sel = SRC_A_SHAMT; end
          FN_SRA:  begin alu_op = ALU_SRA; src_a_sel = SRC_A_SHAMT; end
          FN_JR:   begin alu_op = ALU_PASSA; cls = CLS_JUMP; end
          FN_JALR: begin alu_op = ALU_PASSA; cls = CLS_JLINK; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_REGIMM: begin
        alu_op = ALU_LTZ;
        cls    = CLS_BRANCH;
        case (rt)
          RT_BLTZ: invert = 1'b0;
          RT_BGEZ: invert = 1'b1;
          default: begin alu_op = ALU_AND; cls = CLS_ILLEGAL; end
        endcase
      end
      OP_J:     begin alu_op = ALU_JCONST; src_a_sel = SRC_A_INDEX; cls = CLS_JUMP; end
      OP_JAL:   begin alu_op = ALU_JCONST; src_a_sel = SRC_A_INDEX; cls = CLS_JLINK; end
      OP_BEQ:   begin alu_op = ALU_EQ;  cls = CLS_BRANCH; end
      OP_BNE:   begin alu_op = ALU_EQ;  cls = CLS_BRANCH; invert = 1'b1; end
      OP_BLEZ:  begin alu_op = ALU_LEZ; cls = CLS_BRANCH; end
      OP_BGTZ:  begin alu_op = ALU_LEZ; cls = CLS_BRANCH; invert = 1'b1; end
      OP_ADDIU: begin alu_op = ALU_ADD;  src_b_sel = SRC_B_SIMM; cls = CLS_ALU; end
      OP_SLTI:  begin alu_op = ALU_SLT;  src_b_sel = SRC_B_SIMM; cls = CLS_ALU; end
      OP_SLTIU: begin alu_op = ALU_SLTU; src_b_sel = SRC_B_SIMM; cls = CLS_ALU; end
      OP_ANDI:  begin alu_op = ALU_AND;  src_b_sel = SRC_B_ZIMM; cls = CLS_ALU; end
      OP_ORI:   begin alu_op = ALU_OR;   src_b_sel = SRC_B_ZIMM; cls = CLS_ALU; end
      OP_XORI:  begin alu_op = ALU_XOR;  src_b_sel = SRC_B_ZIMM; cls = CLS_ALU; end
      OP_LW:    begin alu_op = ALU_ADD;  src_b_sel = SRC_B_SIMM; cls = CLS_LOAD; end
      OP_SW:    begin alu_op = ALU_ADD;  src_b_sel = SRC_B_SIMM; cls = CLS_STORE; end
      default:  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Decode results are captured in DECODE so later states see a stable instruction.
// Optional feature macro: ILLEGAL_OPCODE_TRAP_EN (unknown opcode sets illegal and halts).
module mips_control_fsm
  import mips_control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_waitrequest,
  input  logic        cmp_true,
  input  logic        pc_next_zero,
  output logic [4:0]  alu_control,
  output logic [1:0]  src_a_sel,
  output logic [1:0]  src_b_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        active,
  output logic        illegal
);

  state_t       state_q, state_d;
  alu_op_t      alu_op_q, alu_op_d, dec_alu_op_s;
  logic [1:0]   src_a_q, src_a_d, dec_src_a_s;
  logic [1:0]   src_b_q, src_b_d, dec_src_b_s;
  instr_class_t cls_q, cls_d, dec_cls_s;
  logic         invert_q, invert_d, dec_invert_s;
  logic         halt_pend_q, halt_pend_d;
  logic         illegal_q, illegal_d;
  logic         unused_instr_s;

  assign unused_instr_s = ^{instr[25:21], instr[15:6]};

  mips_alu_decoder u_dec (
    .opcode    (instr[31:26]),
    .funct     (instr[5:0]),
    .rt        (instr[20:16]),
    .alu_op    (dec_alu_op_s),
    .src_a_sel (dec_src_a_s),
    .src_b_sel (dec_src_b_s),
    .cls       (dec_cls_s),
    .invert    (dec_invert_s)
  );

  // Next state, decode capture, pending-halt and sticky illegal flag
  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    cls_d       = cls_q;
    invert_d    = invert_q;
    halt_pend_d = halt_pend_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (!mem_waitrequest) state_d = S_DECODE;
        else                  state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_op_d = dec_alu_op_s;
        src_a_d  = dec_src_a_s;
        src_b_d  = dec_src_b_s;
        cls_d    = dec_cls_s;
        invert_d = dec_invert_s;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_ALU:              state_d = S_WB;
          CLS_LOAD, CLS_STORE:  state_d = S_MEM;
          CLS_BRANCH:           state_d = S_FETCH;
          CLS_JUMP:             state_d = pc_next_zero ? S_HALT : S_FETCH;
          CLS_JLINK: begin
            state_d     = S_WB;
            halt_pend_d = pc_next_zero;
          end
          default: begin
            if (TRAP_EN) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              state_d   = S_FETCH;
            end
          end
        endcase
      end
      S_MEM: begin
        if (!mem_waitrequest) state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
        else                  state_d = S_MEM;
      end
      S_WB:    state_d = halt_pend_q ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State and captured-decode registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      alu_op_q    <= ALU_AND;
      src_a_q     <= SRC_A_PC;
      src_b_q     <= SRC_B_RT;
      cls_q       <= CLS_ILLEGAL;
      invert_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      cls_q       <= cls_d;
      invert_q    <= invert_d;
      halt_pend_q <= halt_pend_d;
      illegal_q   <= illegal_d;
    end
  end

  // Moore output decode; reset forces the quiet output set immediately
  always_comb begin
    alu_control = ALU_AND;
    src_a_sel   = SRC_A_PC;
    src_b_sel   = SRC_B_RT;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    active      = 1'b1;
    illegal     = 1'b0;
    if (reset) begin
      active = 1'b1;
    end else begin
      illegal = TRAP_EN & illegal_q;
      case (state_q)
        S_FETCH: begin
          mem_read    = 1'b1;
          alu_control = ALU_ADD;
          src_a_sel   = SRC_A_PC;
          src_b_sel   = SRC_B_FOUR;
          ir_write    = ~mem_waitrequest;
          pc_write    = ~mem_waitrequest;
        end
        S_EXEC: begin
          alu_control = alu_op_q;
          src_a_sel   = src_a_q;
          src_b_sel   = src_b_q;
          case (cls_q)
            CLS_BRANCH:          pc_write = cmp_true ^ invert_q;
            CLS_JUMP, CLS_JLINK: pc_write = 1'b1;
            default:             pc_write = 1'b0;
          endcase
        end
        S_MEM: begin
          alu_control = ALU_ADD;
          src_a_sel   = SRC_A_RS;
          src_b_sel   = SRC_B_SIMM;
          mem_read    = (cls_q == CLS_LOAD);
          mem_write   = (cls_q == CLS_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          if (cls_q == CLS_JLINK) begin
            alu_control = ALU_LINK;
            src_a_sel   = SRC_A_PC;
            src_b_sel   = SRC_B_FOUR;
          end else if (cls_q == CLS_ALU) begin
            alu_control = alu_op_q;
            src_a_sel   = src_a_q;
            src_b_sel   = src_b_q;
          end else begin
            alu_control = ALU_AND;
          end
        end
        S_HALT:  active = 1'b0;
        default: active = 1'b1;
      endcase
    end
  end

endmodule
